layer_header_engine: RTL

//  Parametrised layer-header register file plus per-frame motion/animation updater.

---
 rtl/layer_header_engine.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/layer_header_engine.sv
// ============================================================================
// Module   : layer_header_engine
// Summary  : Layer-header register file, 2-stage pixel hit query, and a
//            per-frame motion/animation updater.
// Revision : 1.0
// ============================================================================
`default_nettype none

module layer_header_engine #(
    parameter  int NUM_LAYERS = 32,
    parameter  int COORD_W    = 11,
    localparam int LW         = $clog2(NUM_LAYERS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LW-1:0]      ctrl_layer,
    input  logic [2:0]         ctrl_reg,
    input  logic [15:0]        ctrl_wdata,
    input  logic               ctrl_wr,
    input  logic               ctrl_rd,
    input  logic               ctrl_clear,
    output logic               ctrl_ready,
    output logic [15:0]        ctrl_rdata,
    output logic               ctrl_rvalid,
    input  logic               frame_start,
    output logic               update_busy,
    output logic               update_done,
    input  logic               pix_valid,
    input  logic [LW-1:0]      pix_layer,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               out_valid,
    output logic               out_hit,
    output logic               out_sprite,
    output logic [15:0]        out_local_x,
    output logic [15:0]        out_local_y,
    output logic [7:0]         out_frame,
    output logic [7:0]         out_layer_id
);

    localparam logic [1:0]    c_ST_IDLE = 2'd0;
    localparam logic [1:0]    c_ST_RD   = 2'd1;
    localparam logic [1:0]    c_ST_WR   = 2'd2;
    localparam logic [1:0]    c_ST_DONE = 2'd3;
    localparam logic [LW-1:0] c_LAST    = LW'(NUM_LAYERS - 1);

    logic [15:0]   r_regs [NUM_LAYERS][8];
    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [LW-1:0] r_layer;
    logic [15:0]   r_new_x, r_new_y, r_new_r7;

    logic w_ready, w_acc_clr, w_acc_wr, w_acc_rd;

    assign w_ready   = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);
    assign w_acc_clr = ctrl_clear & w_ready;
    assign w_acc_wr  = ctrl_wr & w_ready & ~ctrl_clear;
    assign w_acc_rd  = ctrl_rd & w_ready & ~ctrl_clear;

    // ---------------- FSM: state register / next state / outputs ----------
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (frame_start) w_next = c_ST_RD;
            c_ST_RD:   w_next = c_ST_WR;
            c_ST_WR:   w_next = (r_layer == c_LAST) ? c_ST_DONE : c_ST_RD;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_ready  = w_ready;
        update_busy = (r_state == c_ST_RD) || (r_state == c_ST_WR);
        update_done = (r_state == c_ST_DONE);
    end

    // ---------------- Update datapath ----------------
    logic [15:0] w_flags, w_r7;
    logic        w_mov, w_anim;
    logic [8:0]  w_inc;
    logic [7:0]  w_nf;

    assign w_flags = r_regs[r_layer][0];
    assign w_r7    = r_regs[r_layer][7];
    assign w_mov   = w_flags[0] & w_flags[1];
    assign w_anim  = w_mov & w_flags[3] & (w_r7[7:0] != 8'd0);
    assign w_inc   = {1'b0, w_r7[15:8]} + 9'd1;
    assign w_nf    = (w_inc >= {1'b0, w_r7[7:0]}) ? 8'd0 : w_inc[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_layer  <= '0;
            r_new_x  <= '0;
            r_new_y  <= '0;
            r_new_r7 <= '0;
        end else begin
            if (r_state == c_ST_IDLE && frame_start) r_layer <= '0;
            else if (r_state == c_ST_WR)             r_layer <= r_layer + 1'b1;
            if (r_state == c_ST_RD) begin
                r_new_x  <= w_mov ? r_regs[r_layer][3] + r_regs[r_layer][5] : r_regs[r_layer][3];
                r_new_y  <= w_mov ? r_regs[r_layer][4] + r_regs[r_layer][6] : r_regs[r_layer][4];
                r_new_r7 <= w_anim ? {w_nf, w_r7[7:0]} : w_r7;
            end
        end
    end

    // Controller writes cannot collide with WR: ctrl_ready is low there.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < NUM_LAYERS; l++)
                for (int j = 0; j < 8; j++)
                    r_regs[l][j] <= '0;
        end else if (r_state == c_ST_WR) begin
            r_regs[r_layer][3] <= r_new_x;
            r_regs[r_layer][4] <= r_new_y;
            r_regs[r_layer][7] <= r_new_r7;
        end else if (w_acc_clr) begin
            for (int j = 0; j < 8; j++)
                r_regs[ctrl_layer][j] <= '0;
        end else if (w_acc_wr) begin
            r_regs[ctrl_layer][ctrl_reg] <= ctrl_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_rdata  <= '0;
            ctrl_rvalid <= 1'b0;
        end else begin
            ctrl_rvalid <= w_acc_rd;
            if (w_acc_rd) ctrl_rdata <= r_regs[ctrl_layer][ctrl_reg];
        end
    end

    // ---------------- Pixel query pipeline ----------------
    logic        r_s1_valid, r_s1_pop, r_s1_hid, r_s1_spr;
    logic [15:0] r_s1_w, r_s1_h, r_s1_cnt, r_s1_lx, r_s1_ly;
    logic [7:0]  r_s1_frame, r_s1_id;
    logic [15:0] w_px, w_py;
    logic [31:0] w_limit;
    logic        w_hit;

    assign w_px = {{(16-COORD_W){1'b0}}, pix_x};
    assign w_py = {{(16-COORD_W){1'b0}}, pix_y};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_pop   <= 1'b0;
            r_s1_hid   <= 1'b0;
            r_s1_spr   <= 1'b0;
            r_s1_w     <= '0;
            r_s1_h     <= '0;
            r_s1_cnt   <= '0;
            r_s1_lx    <= '0;
            r_s1_ly    <= '0;
            r_s1_frame <= '0;
            r_s1_id    <= '0;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_pop   <= r_regs[pix_layer][0][0];
            r_s1_spr   <= r_regs[pix_layer][0][1];
            r_s1_hid   <= r_regs[pix_layer][0][2];
            r_s1_id    <= r_regs[pix_layer][0][15:8];
            r_s1_w     <= r_regs[pix_layer][1];
            r_s1_h     <= r_regs[pix_layer][2];
            r_s1_lx    <= w_px - r_regs[pix_layer][3];
            r_s1_ly    <= w_py - r_regs[pix_layer][4];
            r_s1_cnt   <= r_regs[pix_layer][6];
            r_s1_frame <= r_regs[pix_layer][7][15:8];
        end
    end

    // Text layers span width * character count pixels horizontally.
    assign w_limit = r_s1_spr ? {16'd0, r_s1_w} : (32'(r_s1_w) * 32'(r_s1_cnt));
    assign w_hit   = r_s1_pop & ~r_s1_hid & ~r_s1_lx[15] & ~r_s1_ly[15]
                   & (r_s1_ly < r_s1_h) & ({16'd0, r_s1_lx} < w_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_hit      <= 1'b0;
            out_sprite   <= 1'b0;
            out_local_x  <= '0;
            out_local_y  <= '0;
            out_frame    <= '0;
            out_layer_id <= '0;
        end else begin
            out_valid    <= r_s1_valid;
            out_hit      <= w_hit;
            out_sprite   <= r_s1_spr;
            out_local_x  <= r_s1_lx;
            out_local_y  <= r_s1_ly;
            out_frame    <= r_s1_frame;
            out_layer_id <= r_s1_id;
        end
    end

endmodule

`default_nettype wire
